// File: rtl/tmds_encoder_3ch_pkg.sv
// Shared TMDS types, control-token constants and helpers for the 3-channel DVI encoder.
package tmds_pkg;

    typedef logic [9:0]        tmds_sym_t;
    typedef logic signed [4:0] tmds_disp_t;

    localparam tmds_sym_t TMDS_CTRL_00 = 10'h354;
    localparam tmds_sym_t TMDS_CTRL_01 = 10'h0AB;
    localparam tmds_sym_t TMDS_CTRL_10 = 10'h154;
    localparam tmds_sym_t TMDS_CTRL_11 = 10'h2AB;

    function automatic logic [3:0] popcount8(input logic [7:0] d);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + 4'(d[i]);
        end
        return n;
    endfunction

    // ctrl is {C1, C0}
    function automatic tmds_sym_t ctrl_token(input logic [1:0] ctrl);
        tmds_sym_t tok;
        case (ctrl)
            2'b00:   tok = TMDS_CTRL_00;
            2'b01:   tok = TMDS_CTRL_01;
            2'b10:   tok = TMDS_CTRL_10;
            default: tok = TMDS_CTRL_11;
        endcase
        return tok;
    endfunction

endpackage

// File: rtl/tmds_encoder_3ch_if.sv
// Video-in / TMDS-symbol-out bundle between the pixel source, the encoder and the serializer.
interface tmds_encoder_3ch_if;
    import tmds_pkg::*;

    logic [7:0] video_r;
    logic [7:0] video_g;
    logic [7:0] video_b;
    logic       video_de;
    logic       video_hsync;
    logic       video_vsync;
    tmds_sym_t  r;
    tmds_sym_t  g;
    tmds_sym_t  b;
    logic       de_out;

    modport master (
        output video_r, video_g, video_b, video_de, video_hsync, video_vsync,
        input  r, g, b, de_out
    );

    modport slave (
        input  video_r, video_g, video_b, video_de, video_hsync, video_vsync,
        output r, g, b, de_out
    );

endinterface

// File: rtl/tmds_channel_encoder.sv
// One TMDS 8b/10b channel: stage 1 builds the transition-minimised q_m, stage 2 balances DC
// against the channel's running disparity and emits the 10-bit symbol.
module tmds_channel_encoder
    import tmds_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] d,
    input  logic       de,
    input  logic       c0,
    input  logic       c1,
    output tmds_sym_t  q
);

    logic [3:0] w_n1d;
    logic       w_xnor;
    logic [8:0] w_qm;

    logic [8:0] r_qm;
    logic [3:0] r_n1q;
    logic       r_de;
    logic [1:0] r_ctrl;

    tmds_disp_t r_cnt;
    tmds_sym_t  r_q;

    tmds_disp_t w_diff;
    tmds_disp_t w_two_qm8;
    tmds_disp_t w_two_nqm8;
    tmds_sym_t  w_sym;
    tmds_disp_t w_cnt_next;
    logic       w_n1_gt;
    logic       w_n0_gt;

    always_comb begin
        w_n1d   = popcount8(d);
        w_xnor  = (w_n1d > 4'd4) || ((w_n1d == 4'd4) && !d[0]);
        w_qm[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            w_qm[i] = w_xnor ? ~(w_qm[i-1] ^ d[i]) : (w_qm[i-1] ^ d[i]);
        end
        w_qm[8] = ~w_xnor;
    end

    // NOTE: non-blocking assignments in every clocked block, so each register sees the
    // pre-edge value of the others regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_qm   <= '0;
            r_n1q  <= '0;
            r_de   <= 1'b0;
            r_ctrl <= 2'b00;
        end else begin
            r_qm   <= w_qm;
            r_n1q  <= popcount8(w_qm[7:0]);
            r_de   <= de;
            r_ctrl <= {c1, c0};
        end
    end

    // N1q - N0q == 2*N1q - 8; modulo-32 wrap is harmless because the result fits in -8..+8.
    assign w_diff     = tmds_disp_t'({r_n1q, 1'b0}) - tmds_disp_t'(5'd8);
    assign w_two_qm8  = tmds_disp_t'({3'b000, r_qm[8], 1'b0});
    assign w_two_nqm8 = tmds_disp_t'({3'b000, ~r_qm[8], 1'b0});
    assign w_n1_gt    = r_n1q > 4'd4;
    assign w_n0_gt    = r_n1q < 4'd4;

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        w_sym      = {~r_qm[8], r_qm[8], r_qm[8] ? r_qm[7:0] : ~r_qm[7:0]};
        w_cnt_next = r_cnt;
        if (!r_de) begin
            w_sym      = ctrl_token(r_ctrl);
            w_cnt_next = '0;
        end else if ((r_cnt == 5'sd0) || (r_n1q == 4'd4)) begin
            w_cnt_next = r_qm[8] ? (r_cnt + w_diff) : (r_cnt - w_diff);
        end else if ((!r_cnt[4] && w_n1_gt) || (r_cnt[4] && w_n0_gt)) begin
            w_sym      = {1'b1, r_qm[8], ~r_qm[7:0]};
            w_cnt_next = r_cnt + w_two_qm8 - w_diff;
        end else begin
            w_sym      = {1'b0, r_qm[8], r_qm[7:0]};
            w_cnt_next = r_cnt - w_two_nqm8 + w_diff;
        end
    end

    // NOTE: the idle token is the reset value so the link shows a legal control period
    // from the moment reset asserts, without waiting for a clock.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_q   <= TMDS_CTRL_00;
            r_cnt <= '0;
        end else begin
            r_q   <= w_sym;
            r_cnt <= w_cnt_next;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/tmds_encoder_3ch.sv
// Three-channel DVI/TMDS encoder: blue carries HSYNC/VSYNC during blanking, DE is
// delayed to stay aligned with the two-stage channel pipelines.
module tmds_encoder_3ch
    import tmds_pkg::*;
(
    input  logic               clk_pixel,
    input  logic               clk_pixel_resetn,
    tmds_encoder_3ch_if.slave  vid
);

    logic r_de_d1;
    logic r_de_d2;

    tmds_channel_encoder u_enc_b (
        .clk    (clk_pixel),
        .resetn (clk_pixel_resetn),
        .d      (vid.video_b),
        .de     (vid.video_de),
        .c0     (vid.video_hsync),
        .c1     (vid.video_vsync),
        .q      (vid.b)
    );

    tmds_channel_encoder u_enc_g (
        .clk    (clk_pixel),
        .resetn (clk_pixel_resetn),
        .d      (vid.video_g),
        .de     (vid.video_de),
        .c0     (1'b0),
        .c1     (1'b0),
        .q      (vid.g)
    );

    tmds_channel_encoder u_enc_r (
        .clk    (clk_pixel),
        .resetn (clk_pixel_resetn),
        .d      (vid.video_r),
        .de     (vid.video_de),
        .c0     (1'b0),
        .c1     (1'b0),
        .q      (vid.r)
    );

    always_ff @(posedge clk_pixel or negedge clk_pixel_resetn) begin
        if (!clk_pixel_resetn) begin
            r_de_d1 <= 1'b0;
            r_de_d2 <= 1'b0;
        end else begin
            r_de_d1 <= vid.video_de;
            r_de_d2 <= r_de_d1;
        end
    end

    assign vid.de_out = r_de_d2;

endmodule

// File: tb/tb_tmds_encoder_3ch.sv
// Self-checking bench: directed reset/control/DC-balance cases, then random video runs
// compared against a DVI-level reference model plus a decoder and disparity monitor.
module tb_tmds_encoder_3ch;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;
    int   n_fail;

    tmds_encoder_3ch_if vif ();

    tmds_encoder_3ch dut (
        .clk_pixel        (clk),
        .clk_pixel_resetn (rst_n),
        .vid              (vif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] r, g, b;
        logic [7:0] dr, dg, db;
        logic       de;
    } exp_t;

    exp_t exp_q[$];
    int   cnt_m[3];
    int   cum[3];

    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference encoder: the DVI 1.0 rules, tracking disparity as the ones-minus-zeros
    // balance of the symbols actually sent since the last blanking period.
    function automatic logic [9:0] ref_enc(input int ch, input logic [7:0] d,
                                           input logic de, input logic [1:0] c);
        logic [7:0] qm;
        logic       qm8, inv, xn;
        int         n1, disp_qm;
        logic [9:0] sym;
        if (!de) begin
            cnt_m[ch] = 0;
            case (c)
                2'b00:   return 10'h354;
                2'b01:   return 10'h0AB;
                2'b10:   return 10'h154;
                default: return 10'h2AB;
            endcase
        end
        n1 = $countones(d);
        xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i] ^ xn;
        qm8 = !xn;
        disp_qm = 2 * $countones(qm) - 8;
        if (cnt_m[ch] == 0 || disp_qm == 0) inv = !qm8;
        else                                inv = ((cnt_m[ch] > 0) == (disp_qm > 0));
        sym = {inv, qm8, inv ? ~qm : qm};
        cnt_m[ch] += 2 * $countones(sym) - 10;
        return sym;
    endfunction

    function automatic logic [7:0] ref_dec(input logic [9:0] s);
        logic [7:0] q, d;
        q = s[9] ? ~s[7:0] : s[7:0];
        d[0] = q[0];
        for (int i = 1; i < 8; i++) d[i] = q[i] ^ q[i-1] ^ !s[8];
        return d;
    endfunction

    task automatic reset_model();
        exp_t idle;
        for (int i = 0; i < 3; i++) begin
            cnt_m[i] = 0;
            cum[i]   = 0;
        end
        exp_q.delete();
        idle = '{r: 10'h354, g: 10'h354, b: 10'h354, dr: 8'h00, dg: 8'h00, db: 8'h00, de: 1'b0};
        exp_q.push_back(idle);
    endtask

    task automatic drive(input logic [7:0] vr, vg, vb, input logic de, hs, vs);
        vif.video_r     = vr;
        vif.video_g     = vg;
        vif.video_b     = vb;
        vif.video_de    = de;
        vif.video_hsync = hs;
        vif.video_vsync = vs;
    endtask

    // One pixel: drive, predict, clock, then compare the output due after this edge.
    task automatic step(input logic [7:0] vr, vg, vb, input logic de, hs, vs);
        exp_t       e;
        logic [9:0] obs[3];
        logic [7:0] dat[3];
        drive(vr, vg, vb, de, hs, vs);
        e.r  = ref_enc(0, vr, de, 2'b00);
        e.g  = ref_enc(1, vg, de, 2'b00);
        e.b  = ref_enc(2, vb, de, {vs, hs});
        e.dr = vr;
        e.dg = vg;
        e.db = vb;
        e.de = de;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() > 1) begin
            e = exp_q.pop_front();
            check("sym_r", vif.r, e.r);
            check("sym_g", vif.g, e.g);
            check("sym_b", vif.b, e.b);
            check("de_out", 10'(vif.de_out), 10'(e.de));
            obs = '{vif.r, vif.g, vif.b};
            dat = '{e.dr, e.dg, e.db};
            for (int ch = 0; ch < 3; ch++) begin
                if (e.de) begin
                    check("decode", 10'(ref_dec(obs[ch])), 10'(dat[ch]));
                    cum[ch] += 2 * $countones(obs[ch]) - 10;
                    check("disp_bound", 10'(cum[ch] >= -8 && cum[ch] <= 8), 10'd1);
                end else begin
                    cum[ch] = 0;
                end
            end
        end
    endtask

    task automatic blank();
        step(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic       de_r;
        int         run_left;
        logic [1:0] c;
        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;
        rst_n    = 1'b0;

        // Reset held with random inputs toggling.
        for (int i = 0; i < 4; i++) begin
            drive(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            @(posedge clk);
            #1;
            check("rst_r", vif.r, 10'h354);
            check("rst_g", vif.g, 10'h354);
            check("rst_b", vif.b, 10'h354);
            check("rst_de", 10'(vif.de_out), 10'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        reset_model();

        // Control tokens on blue, one (vsync,hsync) combination at a time.
        for (int k = 0; k < 4; k++) begin
            c = 2'(k);
            repeat (3) step(8'($urandom), 8'($urandom), 8'($urandom), 1'b0, c[0], c[1]);
        end
        step(8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        check("ctrl_latency_hold", vif.b, 10'h2AB);
        step(8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        check("ctrl_latency_new", vif.b, 10'h0AB);
        check("ctrl_g_idle", vif.g, 10'h354);

        // DC balance on a run of zeros: alternating 0x100/0x3FF, back to zero after word 9.
        blank();
        for (int i = 0; i < 10; i++) begin
            step(8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
            if (i >= 1) check("zeros_seq", vif.g, ((i - 1) % 2 == 1) ? 10'h3FF : 10'h100);
        end
        blank();
        check("zeros_word10", vif.g, 10'h100);

        // XNOR path: 0xFF from cnt 0, then a zero word proves cnt went negative.
        step(8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
        step(8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        check("xnor_ff", vif.r, 10'h200);
        blank();
        check("xnor_after", vif.r, 10'h3FF);

        // Disparity clear across a single-cycle blank.
        blank();
        repeat (3) step(8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        blank();
        check("clr_word3", vif.b, 10'h100);
        step(8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        blank();
        check("clr_post_blank", vif.b, 10'h100);

        // Reset asserted mid-stream takes effect without a clock edge.
        repeat (5) step(8'($urandom), 8'($urandom), 8'($urandom), 1'b1, 1'b0, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_r", vif.r, 10'h354);
        check("async_rst_g", vif.g, 10'h354);
        check("async_rst_b", vif.b, 10'h354);
        check("async_rst_de", 10'(vif.de_out), 10'd0);
        @(negedge clk);
        rst_n = 1'b1;
        reset_model();

        // Random video: DE runs of random length (including single cycles), random syncs.
        de_r     = 1'b0;
        run_left = 0;
        for (int i = 0; i < 10000; i++) begin
            if (run_left == 0) begin
                de_r     = ~de_r;
                run_left = ($urandom_range(0, 9) == 0) ? 1 : $urandom_range(1, 24);
            end
            run_left--;
            step(8'($urandom), 8'($urandom), 8'($urandom), de_r, 1'($urandom), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
